// File: rtl/mem_arb_pkg.sv
// Shared types and parameter limits for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Supported range of the memory read latency.
  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  function automatic bit mem_latency_ok(input int unsigned lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared memory port.
// slave: the arbiter's view; master: the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Fetch stage
  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    flush_if;
  logic                    if_gnt;
  logic                    if_valid;
  logic [DATA_WIDTH-1:0]   if_rdata;
  // Memory (load/store) stage
  logic                    d_req;
  logic                    d_we;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic                    d_gnt;
  logic                    d_valid;
  logic [DATA_WIDTH-1:0]   d_rdata;
  // On-chip memory
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  // Hazard unit
  logic                    stall_if;
  logic                    stall_mem;

  modport slave (
    input  if_req, if_addr, flush_if, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, flush_if, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port on-chip memory between instruction fetch and the load/store stage.
// Data wins by default; fetch wins after MAX_STARVE consecutive losses. Each access owns the
// port for MEM_LATENCY cycles and the next arbitration overlaps its completion cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_STARVE  = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned LatW    = $clog2(MEM_LATENCY + 1);
  localparam int unsigned StarveW = $clog2(MAX_STARVE + 1);

  if (!mem_latency_ok(MEM_LATENCY) || (MAX_STARVE < 1)) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LATENCY must be 1..4 and MAX_STARVE at least 1");
  end

  arb_state_t         r_state, w_state_next;
  logic [LatW-1:0]    r_lat_cnt, w_lat_cnt_next;
  logic [StarveW-1:0] r_starve_cnt, w_starve_cnt_next;
  logic               r_drop, w_drop_next;

  logic   w_busy, w_complete, w_arb, w_if_win, w_d_win, w_if_valid, w_d_valid;
  owner_t w_winner;

  // Arbitration: only when idle or in the completion cycle of the current access.
  always_comb begin
    w_busy     = (r_state != IDLE);
    w_complete = w_busy && (r_lat_cnt == LatW'(1));
    w_arb      = !w_busy || w_complete;
    w_if_win   = w_arb && bus.if_req &&
                 (!bus.d_req || (r_starve_cnt == StarveW'(MAX_STARVE)));
    w_d_win    = w_arb && bus.d_req && !w_if_win;
    w_winner   = w_if_win ? OWN_IF : OWN_D;
    // A flush seen earlier in the access or in this very cycle kills the fetch response.
    w_if_valid = w_complete && (r_state == BUSY_IF) && !r_drop && !bus.flush_if;
    w_d_valid  = w_complete && (r_state == BUSY_D);
  end

  // Outputs: grants, memory command, responses and stalls, all forced low during reset.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_valid  = 1'b0;
    bus.d_valid   = 1'b0;
    bus.if_rdata  = '0;
    bus.d_rdata   = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    bus.stall_if  = 1'b0;
    bus.stall_mem = 1'b0;
    if (!rst) begin
      bus.if_gnt    = w_if_win;
      bus.d_gnt     = w_d_win;
      bus.if_valid  = w_if_valid;
      bus.d_valid   = w_d_valid;
      bus.if_rdata  = w_if_valid ? bus.mem_rdata : '0;
      bus.d_rdata   = w_d_valid ? bus.mem_rdata : '0;
      bus.stall_if  = bus.if_req && !w_if_valid;
      bus.stall_mem = bus.d_req && !w_d_valid;
      if (w_if_win || w_d_win) begin
        bus.mem_en = 1'b1;
        unique case (w_winner)
          OWN_IF: begin
            bus.mem_addr = bus.if_addr;
            bus.mem_be   = '1;
          end
          OWN_D: begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_be    = bus.d_be;
          end
        endcase
      end
    end
  end

  // Next state: owner, latency countdown, flush drop flag and fetch starvation count.
  always_comb begin
    w_state_next      = r_state;
    w_lat_cnt_next    = r_lat_cnt;
    w_drop_next       = r_drop;
    w_starve_cnt_next = r_starve_cnt;
    if (w_if_win || w_d_win) begin
      w_state_next   = w_if_win ? BUSY_IF : BUSY_D;
      w_lat_cnt_next = LatW'(MEM_LATENCY);
      w_drop_next    = 1'b0;
    end else if (w_complete) begin
      w_state_next   = IDLE;
      w_lat_cnt_next = '0;
      w_drop_next    = 1'b0;
    end else if (w_busy) begin
      w_lat_cnt_next = r_lat_cnt - LatW'(1);
      if ((r_state == BUSY_IF) && bus.flush_if) begin
        w_drop_next = 1'b1;
      end
    end
    if (w_if_win || !bus.if_req) begin
      w_starve_cnt_next = '0;
    end else if (w_d_win && (r_starve_cnt != StarveW'(MAX_STARVE))) begin
      w_starve_cnt_next = r_starve_cnt + StarveW'(1);
    end
  end

  // State registers with synchronous reset; an in-flight response is simply forgotten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_lat_cnt    <= w_lat_cnt_next;
      r_starve_cnt <= w_starve_cnt_next;
      r_drop       <= w_drop_next;
    end
  end

endmodule
